drop_controller: RTL and testbench
==================================

# drop_controller

Gravity/spawn sequencer that drives the 16-bit falling-piece shift register directly downstream: it loads a new piece pattern, then issues one-cycle shift-enable pulses at the gravity rate (or the faster soft-drop rate) until the piece reaches the bottom row or the board logic reports a collision. It watches the register's parallel output as feedback and signals landing to the game controller.

## Interface
- `TICK_DIV`, default 25_000_000: normal gravity period in clocks (0.5 s at 50 MHz); must be ≥ 2.
- `FAST_DIV`, default 2_500_000: soft-drop period in clocks; 1 ≤ `FAST_DIV` ≤ `TICK_DIV`.
- `Clock` in 1: system clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Start` in 1: request to spawn a piece; sampled only in IDLE.
- `Pattern` in 16: piece pattern, captured with `Start`.
- `Drop` in 1: soft drop; level-sensitive, selects `FAST_DIV`.
- `Collide` in 1: board logic says the next shift would overlap settled blocks.
- `Pos` in 16: current shift-register contents (feedback).
- `R` out 16: registered pattern for the parallel load.
- `Load` out 1: parallel-load strobe.
- `Enable` out 1: shift strobe.
- `Landed` out 1: one-cycle pulse when the piece stops.
- `Busy` out 1: high from SPAWN through LAND inclusive.
- `Row` out 4: number of shifts issued for the current piece.

## Operation
- States: IDLE, SPAWN, SETTLE, FALL, SHIFT, LAND. All outputs are registered and Moore-decoded.
- IDLE: if `Start`=1 and `Pattern`≠0, capture `Pattern` into `R`, clear `Row`, and go to SPAWN. If `Pattern`=0, ignore `Start` and stay in IDLE.
- SPAWN: `Load`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one idle cycle so `Pos` reflects the last load or shift. Clear the tick counter, then go to FALL.
- FALL: the tick counter increments each cycle. Divisor = `Drop` ? `FAST_DIV` : `TICK_DIV`, evaluated every cycle.
- Terminal condition: counter ≥ divisor−1. This covers `Drop` rising mid-count past `FAST_DIV`−1, which ticks immediately.
- At terminal: if `Pos[15]`=1 or `Collide`=1, go to LAND; otherwise go to SHIFT.
- SHIFT: `Enable`=1 for one cycle. `Row` increments, saturating at 15. Then go to SETTLE.
- LAND: `Landed`=1 for one cycle, then go to IDLE. `Row` and `R` hold their values until the next spawn.
- `Start` outside IDLE is ignored; no queuing.
- `Load` and `Enable` are never high in the same cycle.

## Timing
- Reset (asynchronous, any state): state=IDLE; `R`=0, `Load`=0, `Enable`=0, `Landed`=0, `Busy`=0, `Row`=0, counter=0. Reset mid-fall abandons the piece with no `Landed` pulse.
- `Start` sampled at edge n: `Load`=1 and `Busy`=1 in cycle n+1.
- After `Load`: first terminal evaluation comes 1 (SETTLE) + div cycles later.
- Steady shift period: div + 2 clocks (div FALL + SHIFT + SETTLE).
- Landing: `Landed` is asserted the cycle after the terminal FALL cycle. `Busy` drops, and IDLE is entered one cycle later.
- Back-to-back pieces: `Start` held high during LAND is accepted in the first IDLE cycle.
- Counter width: $clog2(`TICK_DIV`) bits.

## Structure
- Package `drop_pkg`:
  - state enum with explicit 3-bit encoding (IDLE=0, SPAWN=1, SETTLE=2, FALL=3, SHIFT=4, LAND=5);
  - `ROW_W`=4;
  - `BOARD_W`=16.
- Sub-module `tick_counter`: clear, enable, divisor input, and a terminal flag output. It holds the only wide counter.
- The FSM and output registers stay in `drop_controller`.

## Test plan
All scenarios use `TICK_DIV`=4 and `FAST_DIV`=2, with the downstream shift register instantiated to drive `Pos`.
- Reset: assert `Resetn`=0 mid-FALL, asynchronously → all outputs 0 immediately; IDLE after release, no `Landed`.
- Normal fall: `Start` with `Pattern`=16'h0003 → `Load` one cycle later; `Enable` pulses every 6 cycles. Exactly 14 pulses bring `Pos[15]`=1, then `Landed` one pulse with `Row`=14.
- Soft drop: same spawn with `Drop`=1 throughout → `Enable` period is 4 cycles; `Row`=14 at `Landed`.
- Collision: `Collide` forced high after the 3rd `Enable` → no 4th `Enable`; `Landed` asserts with `Row`=3.
- Ignored requests: `Start` with `Pattern`=0 → stays IDLE, `Load` never asserted. `Start` pulsed during FALL → no reload; `R` unchanged.
- Back-to-back: `Start` held high with `Pattern`=16'h0001 → second `Load` the cycle after IDLE re-entry; `Row` cleared to 0.

Source files
------------

// File: rtl/drop_pkg.sv
// Shared types and constants for the falling-piece drop sequencer.
package drop_pkg;

    localparam int ROW_W   = 4;
    localparam int BOARD_W = 16;

    // Sequencer states; the encoding is fixed so it can be decoded on a bus probe.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        SETTLE = 3'd2,
        FALL   = 3'd3,
        SHIFT  = 3'd4,
        LAND   = 3'd5
    } state_t;

    // Row count increment that sticks at the top value instead of wrapping.
    function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] row);
        return (row == {ROW_W{1'b1}}) ? row : row + 1'b1;
    endfunction

endpackage

// File: rtl/drop_controller_if.sv
// Signal bundle between the drop sequencer, the game controller and the
// falling-piece shift register it drives.
interface drop_controller_if;
    import drop_pkg::*;

    logic               Start;
    logic [BOARD_W-1:0] Pattern;
    logic               Drop;
    logic               Collide;
    logic [BOARD_W-1:0] Pos;
    logic [BOARD_W-1:0] R;
    logic               Load;
    logic               Enable;
    logic               Landed;
    logic               Busy;
    logic [ROW_W-1:0]   Row;

    // Sequencer side: consumes requests and feedback, drives strobes and status.
    modport master (
        input  Start, Pattern, Drop, Collide, Pos,
        output R, Load, Enable, Landed, Busy, Row
    );

    // Environment side: game controller, board logic and shift register.
    modport slave (
        output Start, Pattern, Drop, Collide, Pos,
        input  R, Load, Enable, Landed, Busy, Row
    );
endinterface

// File: rtl/drop_controller_tick_counter.sv
// Gravity tick counter: cleared once per row, counts while enabled and flags
// when the count has reached the selected divisor minus one.
module tick_counter #(
    parameter int CNT_W = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_m1,
    output logic             terminal
);

    logic [CNT_W-1:0] count_reg;

    // Count register: clear has priority over counting.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Greater-or-equal rather than equality so a divisor that shrinks
    // mid-count (soft drop pressed late) ticks straight away.
    assign terminal = (count_reg >= div_m1);

endmodule

// File: rtl/drop_controller.sv
// Gravity/spawn sequencer: loads a piece into the downstream shift register,
// pulses the shift enable at the gravity or soft-drop rate, and reports
// landing when the piece reaches the bottom row or hits settled blocks.
module drop_controller
    import drop_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int FAST_DIV = 2_500_000
) (
    input  logic              Clock,
    input  logic              Resetn,
    drop_controller_if.master bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_M1 = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);

    state_t             state_reg, state_next;
    logic [BOARD_W-1:0] r_reg, r_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic               load_reg, load_next;
    logic               enable_reg, enable_next;
    logic               landed_reg, landed_next;
    logic               busy_reg, busy_next;

    logic               cnt_clear;
    logic               cnt_enable;
    logic               cnt_terminal;
    logic [CNT_W-1:0]   div_m1;

    // Divisor follows the soft-drop level every cycle.
    assign div_m1 = bus.Drop ? FAST_M1 : TICK_M1;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .div_m1   (div_m1),
        .terminal (cnt_terminal)
    );

    // Next-state, datapath and Moore output decode from the upcoming state.
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        row_next   = row_reg;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_reg)
            IDLE: begin
                // An all-zero pattern is not a piece; the request is dropped.
                if (bus.Start && (bus.Pattern != '0)) begin
                    state_next = SPAWN;
                    r_next     = bus.Pattern;
                    row_next   = '0;
                end
            end
            SPAWN: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                cnt_clear  = 1'b1;
                state_next = FALL;
            end
            FALL: begin
                if (cnt_terminal) begin
                    if (bus.Pos[BOARD_W-1] || bus.Collide) begin
                        state_next = LAND;
                    end else begin
                        state_next = SHIFT;
                        row_next   = row_sat_inc(row_reg);
                    end
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            SHIFT: begin
                state_next = SETTLE;
            end
            LAND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        load_next   = (state_next == SPAWN);
        enable_next = (state_next == SHIFT);
        landed_next = (state_next == LAND);
        busy_next   = (state_next != IDLE);
    end

    // State and output registers; reset abandons any piece in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg  <= IDLE;
            r_reg      <= '0;
            row_reg    <= '0;
            load_reg   <= 1'b0;
            enable_reg <= 1'b0;
            landed_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            r_reg      <= r_next;
            row_reg    <= row_next;
            load_reg   <= load_next;
            enable_reg <= enable_next;
            landed_reg <= landed_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.R      = r_reg;
    assign bus.Row    = row_reg;
    assign bus.Load   = load_reg;
    assign bus.Enable = enable_reg;
    assign bus.Landed = landed_reg;
    assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_drop_controller.sv
// Bench for drop_controller with a behavioural shift register on Pos.
// Expected strobe events are predicted in closed form at spawn time and
// checked by a negedge monitor as the DUT produces them.
module tb_drop_controller;

    localparam int TICK = 4;
    localparam int FAST = 2;

    typedef struct {
        int          kind;   // 0 load, 1 enable, 2 landed
        int          cyc;
        logic [15:0] val;
        int          row;
    } exp_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;

    drop_controller_if dif();

    drop_controller #(
        .TICK_DIV (TICK),
        .FAST_DIV (FAST)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (dif.master)
    );

    always #5 Clock = ~Clock;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   enable_seen = 0;
    int   load_seen = 0;
    int   landed_seen = 0;
    exp_t sb[$];

    always @(posedge Clock) cyc <= cyc + 1;

    // Downstream falling-piece register.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn)         dif.Pos <= '0;
        else if (dif.Load)   dif.Pos <= dif.R;
        else if (dif.Enable) dif.Pos <= dif.Pos << 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int msb_of(input logic [15:0] p);
        for (int i = 15; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    // Event compare: pops the oldest expectation for this strobe.
    task automatic check_event(input int kind, input logic [15:0] val, input int row, input bit busy);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_timing: got kind %0d cycle %0d expected kind %0d cycle %0d",
                     kind, cyc, e.kind, e.cyc);
        end
        chk(kind == 0 ? "load_R" : (kind == 1 ? "enable_Pos" : "landed_Pos"), int'(val), int'(e.val));
        if (e.row >= 0) chk(kind == 0 ? "load_Row" : "landed_Row", row, e.row);
        chk("busy_on_strobe", int'(busy), 1);
    endtask

    // Monitor: one line per observed strobe.
    always @(negedge Clock) begin
        if (dif.Load || dif.Enable || dif.Landed) begin
            chk("load_enable_exclusive", int'(dif.Load && dif.Enable), 0);
            if (dif.Load) begin
                load_seen++;
                $display("cycle %0d: Load R=%h Row=%0d", cyc, dif.R, dif.Row);
                check_event(0, dif.R, int'(dif.Row), dif.Busy);
            end
            if (dif.Enable) begin
                enable_seen++;
                $display("cycle %0d: Enable Pos=%h Row=%0d", cyc, dif.Pos, dif.Row);
                check_event(1, dif.Pos, -1, dif.Busy);
            end
            if (dif.Landed) begin
                landed_seen++;
                $display("cycle %0d: Landed Pos=%h Row=%0d", cyc, dif.Pos, dif.Row);
                check_event(2, dif.Pos, int'(dif.Row), dif.Busy);
            end
        end
    end

    // Closed-form prediction of a piece's strobes, Load at cycle l.
    // coll: number of shifts after which Collide rises (-1 = never).
    function automatic int push_piece(input logic [15:0] p, input bit drop, input int coll, input int l);
        int div = drop ? FAST : TICK;
        int n   = 15 - msb_of(p);
        exp_t e;
        if (coll >= 0 && coll < n) n = coll;
        e.kind = 0; e.cyc = l; e.val = p; e.row = 0;
        sb.push_back(e);
        for (int k = 1; k <= n; k++) begin
            e.kind = 1; e.cyc = l + (div + 2) * k; e.val = p << (k - 1); e.row = -1;
            sb.push_back(e);
        end
        e.kind = 2; e.cyc = l + (div + 2) * (n + 1); e.val = p << n; e.row = (n > 15) ? 15 : n;
        sb.push_back(e);
        return n;
    endfunction

    task automatic issue(input logic [15:0] p, input bit drop, input int coll);
        int n;
        @(posedge Clock); #1;
        dif.Start = 1'b1; dif.Pattern = p; dif.Drop = drop;
        dif.Collide = (coll == 0);
        enable_seen = 0;
        n = push_piece(p, drop, coll, cyc + 1);
        @(posedge Clock); #1;
        dif.Start = 1'b0; dif.Pattern = 16'($urandom);
    endtask

    task automatic wait_done(input int coll);
        int budget = 400;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge Clock); #1;
            if (coll >= 0 && enable_seen >= coll) dif.Collide = 1'b1;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending events expected 0", sb.size());
            sb.delete();
        end
        dif.Collide = 1'b0; dif.Drop = 1'b0;
        chk("busy_after_land", int'(dif.Busy), 0);
    endtask

    initial begin
        int base, budget, n;
        logic [15:0] r_before, p;
        bit d;
        int c;

        dif.Start = 0; dif.Pattern = 0; dif.Drop = 0; dif.Collide = 0;
        #1;
        chk("reset_outputs", int'({dif.R, dif.Load, dif.Enable, dif.Landed, dif.Busy, dif.Row}), 0);
        #11 Resetn = 1'b1;

        // Normal fall, soft drop, collision after the 3rd shift.
        issue(16'h0003, 0, -1); wait_done(-1);
        issue(16'h0003, 1, -1); wait_done(-1);
        issue(16'h0003, 0, 3);  wait_done(3);

        // Start with zero pattern is ignored.
        base = load_seen; r_before = dif.R;
        @(posedge Clock); #1; dif.Start = 1'b1; dif.Pattern = 16'h0000;
        repeat (4) @(posedge Clock); #1; dif.Start = 1'b0;
        chk("zero_pattern_busy", int'(dif.Busy), 0);
        chk("zero_pattern_load", load_seen, base);
        chk("zero_pattern_R", int'(dif.R), int'(r_before));

        // Start pulsed during FALL is ignored.
        issue(16'h0003, 0, -1);
        repeat (3) @(posedge Clock); #1;
        dif.Start = 1'b1; dif.Pattern = 16'hFFFF;
        @(posedge Clock); #1; dif.Start = 1'b0;
        chk("start_in_fall_R", int'(dif.R), 16'h0003);
        wait_done(-1);

        // Back-to-back pieces with Start held high.
        base = load_seen;
        @(posedge Clock); #1;
        dif.Start = 1'b1; dif.Pattern = 16'h0001;
        c = cyc + 1;
        n = push_piece(16'h0001, 0, -1, c);
        n = push_piece(16'h0001, 0, -1, c + (TICK + 2) * (n + 1) + 2);
        budget = 300;
        while (load_seen < base + 2 && budget > 0) begin
            @(posedge Clock); #1; budget--;
        end
        dif.Start = 1'b0;
        chk("back_to_back_loads", load_seen, base + 2);
        wait_done(-1);

        // Randomized pieces.
        for (int i = 0; i < 8; i++) begin
            p = 16'($urandom);
            if (p == 0) p = 16'h0100;
            d = 1'($urandom_range(0, 1));
            c = int'($urandom_range(0, 6)) - 1;
            repeat ($urandom_range(0, 3)) @(posedge Clock);
            issue(p, d, c);
            wait_done(c);
        end

        // Asynchronous reset in the middle of a fall.
        issue(16'h0003, 0, -1);
        budget = 100;
        while (enable_seen < 2 && budget > 0) begin
            @(posedge Clock); #1; budget--;
        end
        chk("pre_reset_enables", enable_seen, 2);
        @(posedge Clock); #3;
        Resetn = 1'b0;
        #1;
        chk("async_reset_outputs", int'({dif.R, dif.Load, dif.Enable, dif.Landed, dif.Busy, dif.Row}), 0);
        sb.delete();
        base = landed_seen;
        @(negedge Clock); @(negedge Clock); #2;
        Resetn = 1'b1;
        repeat (20) @(posedge Clock); #1;
        chk("post_reset_busy", int'(dif.Busy), 0);
        chk("post_reset_no_landed", landed_seen, base);
        chk("post_reset_R", int'(dif.R), 0);

        // Recovery after reset.
        issue(16'h4000, 0, -1); wait_done(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
